// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory controller: load/store with byte and word variants.
// Misaligned words take two row accesses. Contents are filled with byte k = k[7:0] after reset.
module data_memory_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_func,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wb_sel,
  output logic              init_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int ROWS  = DEPTH / BYTES;
  localparam int OFF_W = $clog2(BYTES);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SPLIT = 2'd2;

  localparam logic [1:0] V_LBU  = 2'd0;
  localparam logic [1:0] V_LBS  = 2'd1;
  localparam logic [1:0] V_WORD = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_X    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_OFF_X = (ADDR_W+1)'(BYTES - 1);

  logic [DATA_W-1:0] mem [ROWS];

  logic [1:0]       state_reg;
  logic [ROW_W-1:0] init_row_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic             wb_sel_reg;

  logic [DATA_W-1:0] rd_reg;
  logic [DATA_W-1:0] first_reg;
  logic [OFF_W-1:0]  resp_off_reg;
  logic [1:0]        resp_var_reg;
  logic              resp_split_reg;
  logic [ROW_W-1:0]  split_row_reg;
  logic              split_we_reg;
  logic [DATA_W-1:0] split_wdata_reg;
  logic [BYTES-1:0]  split_be_reg;

  logic [1:0]        req_var;
  logic [OFF_W-1:0]  req_off;
  logic [ROW_W-1:0]  req_row;
  logic [ADDR_W:0]   addr_x;
  logic [ADDR_W:0]   last_x;
  logic              req_err;
  logic              req_split;
  logic              accept;
  logic              unused_func;

  assign req_var     = req_func[2:1];
  assign unused_func = ^{req_func[3], req_func[0]};
  assign req_off     = req_addr[OFF_W-1:0];
  assign req_row     = req_addr[OFF_W+ROW_W-1:OFF_W];
  assign addr_x      = {1'b0, req_addr};
  assign last_x      = addr_x + LAST_OFF_X;

  // Word accesses must fit entirely inside the memory; no wrap-around.
  assign req_err = (req_var == 2'd3) || (req_var == V_LBS && req_we) ||
                   (addr_x >= DEPTH_X) || (req_var == V_WORD && last_x >= DEPTH_X);
  assign req_split = (req_var == V_WORD) && (req_off != '0);
  assign accept    = req_valid && (state_reg == IDLE) && !reset;

  // Store data and byte enables across two rows; the upper halves feed the SPLIT cycle.
  logic [2*DATA_W-1:0] st_wide;
  logic [2*BYTES-1:0]  be_wide;
  logic [BYTES-1:0]    byte_be;

  assign st_wide = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
  assign be_wide = {{BYTES{1'b0}}, {BYTES{1'b1}}} << req_off;
  assign byte_be = {{(BYTES-1){1'b0}}, 1'b1} << req_off;

  logic [DATA_W-1:0] init_data;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_init_byte
    assign init_data[gi*8 +: 8] = 8'(32'(init_row_reg) * 32'(BYTES) + 32'(gi));
  end

  logic              wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic [BYTES-1:0]  wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [ROW_W-1:0]  rd_row;

  always_comb begin
    wr_en   = 1'b0;
    wr_row  = req_row;
    wr_be   = '0;
    wr_data = st_wide[DATA_W-1:0];
    case (state_reg)
      INIT: begin
        wr_en   = 1'b1;
        wr_row  = init_row_reg;
        wr_be   = '1;
        wr_data = init_data;
      end
      SPLIT: begin
        wr_en   = split_we_reg;
        wr_row  = split_row_reg;
        wr_be   = split_be_reg;
        wr_data = split_wdata_reg;
      end
      default: begin
        if (accept && req_we && !req_err) begin
          wr_en = 1'b1;
          wr_be = (req_var == V_WORD) ? be_wide[BYTES-1:0] : byte_be;
        end
      end
    endcase
  end

  assign rd_row = (state_reg == SPLIT) ? split_row_reg : req_row;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) mem[wr_row][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    rd_reg <= mem[rd_row];
  end

  always_ff @(posedge clk) begin
    if (state_reg == SPLIT) first_reg <= rd_reg;
    if (accept) begin
      resp_off_reg    <= req_off;
      resp_var_reg    <= req_var;
      resp_split_reg  <= req_split && !req_err;
      split_row_reg   <= req_row + ROW_W'(1);
      split_we_reg    <= req_we;
      split_wdata_reg <= st_wide[2*DATA_W-1:DATA_W];
      split_be_reg    <= be_wide[2*BYTES-1:BYTES];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= INIT;
      init_row_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      wb_sel_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      wb_sel_reg    <= 1'b0;
      case (state_reg)
        INIT: begin
          init_row_reg <= init_row_reg + ROW_W'(1);
          if (init_row_reg == ROW_W'(ROWS - 1)) state_reg <= IDLE;
        end
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end else if (req_split) begin
              state_reg <= SPLIT;
            end else begin
              rsp_valid_reg <= 1'b1;
              wb_sel_reg    <= !req_we;
            end
          end
        end
        SPLIT: begin
          rsp_valid_reg <= 1'b1;
          wb_sel_reg    <= !split_we_reg;
          state_reg     <= IDLE;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  // Load assembly: for a split word the first row supplies the low bytes.
  logic [2*DATA_W-1:0] rd_wide;
  logic [DATA_W-1:0]   ld_word;
  logic [7:0]          ld_byte;
  logic [DATA_W-1:0]   ld_val;

  assign rd_wide = resp_split_reg ? {rd_reg, first_reg} : {{DATA_W{1'b0}}, rd_reg};
  assign ld_word = DATA_W'(rd_wide >> {resp_off_reg, 3'b000});
  assign ld_byte = ld_word[7:0];

  always_comb begin
    ld_val = ld_word;
    case (resp_var_reg)
      V_LBU:   ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
      V_LBS:   ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      default: ld_val = ld_word;
    endcase
  end

  assign req_ready = (state_reg == IDLE) && !reset;
  assign init_busy = (state_reg == INIT) || reset;
  assign rsp_valid = rsp_valid_reg && !reset;
  assign rsp_err   = rsp_valid && rsp_err_reg;
  assign wb_sel    = rsp_valid && wb_sel_reg;
  assign rsp_data  = wb_sel ? ld_val : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl (DATA_W=16, DEPTH=256): directed vectors, corner sequences,
// and random requests checked against a byte-array reference memory.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_func;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        wb_sel;
  logic        init_busy;

  data_memory_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_sel(wb_sel), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem [256];

  typedef struct {
    logic        we;
    logic [1:0]  v;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ref_init();
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k);
  endtask

  // Reference: memory as plain bytes, rules applied directly to byte addresses.
  task automatic model(input logic we, input logic [1:0] v, input int addr, input logic [15:0] wd,
                       output logic [15:0] d, output logic e, output int lat);
    d   = '0;
    lat = 1;
    e   = (v == 2'd3) || (v == 2'd1 && we) || (addr >= 256) || (v == 2'd2 && addr + 1 >= 256);
    if (!e) begin
      if (v == 2'd2 && (addr % 2) != 0) lat = 2;
      if (we) begin
        ref_mem[addr] = wd[7:0];
        if (v == 2'd2) ref_mem[addr+1] = wd[15:8];
      end else begin
        case (v)
          2'd0:    d = {8'h00, ref_mem[addr]};
          2'd1:    d = {{8{ref_mem[addr][7]}}, ref_mem[addr]};
          default: d = {ref_mem[addr+1], ref_mem[addr]};
        endcase
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] v, input logic [15:0] addr, input logic [15:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_func  = {1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1))};
    req_addr  = addr;
    req_wdata = wd;
  endtask

  // One request, waiting for its response at the expected latency.
  task automatic issue(input string name, input logic we, input logic [1:0] v, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_d, input logic exp_e, input int exp_lat);
    @(negedge clk);
    drive(we, v, addr, wd);
    chk({name, ".ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_lat == 2) begin
      chk({name, ".split_ready"}, 32'(req_ready), 32'd0);
      chk({name, ".split_novalid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ".err"}, 32'(rsp_err), 32'(exp_e));
    chk({name, ".wb_sel"}, 32'(wb_sel), 32'(!exp_e && !we));
    chk({name, ".data"}, 32'(rsp_data), 32'(exp_d));
    $display("[TB] txn %s we=%0d var=%0d addr=%h wdata=%h -> data=%h err=%0d wb=%0d",
             name, we, v, addr, wd, rsp_data, rsp_err, wb_sel);
  endtask

  // Releases reset and measures the initialisation window; optionally holds a store request meanwhile.
  task automatic release_and_init(input logic junk);
    int cnt;
    logic saw;
    @(negedge clk);
    reset = 1'b0;
    if (junk) drive(1'b1, 2'd2, 16'h0010, 16'hDEAD);
    #1;
    cnt = 0;
    saw = 1'b0;
    while (init_busy && cnt < 1000) begin
      if (rsp_valid || req_ready) saw = 1'b1;
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("init_cycles", 32'(cnt), 32'd128);
    chk("ready_after_init", 32'(req_ready), 32'd1);
    chk("quiet_during_init", 32'(saw), 32'd0);
    $display("[TB] txn init busy_cycles=%0d ready=%0d", cnt, req_ready);
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    int          lat;
    logic        we;
    logic [1:0]  v;
    int          addr;
    logic [15:0] wd;

    vecs[0]  = '{1'b0, 2'd2, 16'h0010, 16'h0000, 16'h1110, 1'b0, 1};
    vecs[1]  = '{1'b0, 2'd2, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1};
    vecs[2]  = '{1'b0, 2'd1, 16'h0090, 16'h0000, 16'hFF90, 1'b0, 1};
    vecs[3]  = '{1'b0, 2'd0, 16'h0090, 16'h0000, 16'h0090, 1'b0, 1};
    vecs[4]  = '{1'b0, 2'd1, 16'h0070, 16'h0000, 16'h0070, 1'b0, 1};
    vecs[5]  = '{1'b1, 2'd2, 16'h0021, 16'hBEEF, 16'h0000, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd2, 16'h0021, 16'h0000, 16'hBEEF, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd2, 16'h0022, 16'h0000, 16'h23BE, 1'b0, 1};
    vecs[8]  = '{1'b0, 2'd0, 16'h0020, 16'h0000, 16'h0020, 1'b0, 1};
    vecs[9]  = '{1'b0, 2'd2, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[10] = '{1'b0, 2'd0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[11] = '{1'b0, 2'd3, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[12] = '{1'b1, 2'd2, 16'h00FF, 16'h5555, 16'h0000, 1'b1, 1};
    vecs[13] = '{1'b0, 2'd0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1};
    vecs[14] = '{1'b1, 2'd0, 16'h0007, 16'h1234, 16'h0000, 1'b0, 1};
    vecs[15] = '{1'b0, 2'd0, 16'h0007, 16'h0000, 16'h0034, 1'b0, 1};
    vecs[16] = '{1'b1, 2'd1, 16'h0008, 16'h7777, 16'h0000, 1'b1, 1};
    vecs[17] = '{1'b0, 2'd2, 16'h0007, 16'h0000, 16'h0834, 1'b0, 2};
    vecs[18] = '{1'b0, 2'd1, 16'h00FE, 16'h0000, 16'hFFFE, 1'b0, 1};
    vecs[19] = '{1'b0, 2'd2, 16'h00FE, 16'h0000, 16'hFFFE, 1'b0, 1};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk("reset.init_busy", 32'(init_busy), 32'd1);
    chk("reset.rsp_data", 32'(rsp_data), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.wb_sel", 32'(wb_sel), 32'd0);

    release_and_init(1'b1);
    ref_init();

    for (int i = 0; i < 20; i++) begin
      model(vecs[i].we, vecs[i].v, int'(vecs[i].addr), vecs[i].wd, d, e, lat);
      issue($sformatf("vec%0d", i), vecs[i].we, vecs[i].v, vecs[i].addr, vecs[i].wd,
            vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat);
    end

    // Back-to-back byte store then load of the same byte.
    @(negedge clk);
    drive(1'b1, 2'd0, 16'h0005, 16'h00AA);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0005, 16'h0000);
    chk("b2b.ready2", 32'(req_ready), 32'd1);
    chk("b2b.valid1", 32'(rsp_valid), 32'd1);
    chk("b2b.wb1", 32'(wb_sel), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.valid2", 32'(rsp_valid), 32'd1);
    chk("b2b.data2", 32'(rsp_data), 32'h00AA);
    $display("[TB] txn b2b sb/lbu 0x0005 -> data=%h", rsp_data);
    ref_mem[5] = 8'hAA;

    // Reset during the SPLIT cycle of a misaligned store abandons it.
    @(negedge clk);
    drive(1'b1, 2'd2, 16'h0041, 16'h1234);
    chk("rsplit.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsplit.in_split", 32'(req_ready), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    release_and_init(1'b0);
    ref_init();
    issue("rsplit.lw40", 1'b0, 2'd2, 16'h0040, 16'h0000, 16'h4140, 1'b0, 1);
    issue("rsplit.lw42", 1'b0, 2'd2, 16'h0042, 16'h0000, 16'h4342, 1'b0, 1);

    for (int i = 0; i < 300; i++) begin
      we   = 1'($urandom_range(0, 1));
      v    = 2'($urandom_range(0, 3));
      addr = (i % 5 == 0) ? $urandom_range(250, 260) : $urandom_range(0, 263);
      wd   = 16'($urandom);
      model(we, v, addr, wd, d, e, lat);
      issue($sformatf("rnd%0d", i), we, v, 16'(addr), wd, d, e, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be 16 or 32; BYTES = DATA_W/8.
REQ-002 Parameter DEPTH, default 256: memory size in bytes; SHALL be a power of two and a multiple of BYTES; ROWS = DEPTH/BYTES.
REQ-003 Parameter ADDR_W, default 16: request byte-address width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_func  in  4  operation variant = req_func[2:1]; other bits ignored.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data.
REQ-012 rsp_valid  out  1  one-cycle pulse per accepted request.
REQ-013 rsp_data  out  DATA_W  load result; 0 for stores and errors.
REQ-014 rsp_err  out  1  qualified by rsp_valid; request rejected.
REQ-015 wb_sel  out  1  qualified by rsp_valid; 1 = successful load, register write-back from rsp_data.
REQ-016 init_busy  out  1  initialisation in progress.

Function
REQ-017 Storage SHALL be ROWS rows of DATA_W bits, one row read or written per cycle, with per-byte write enables; byte order little-endian (lowest address in bits [7:0]).
REQ-018 Variants: 00 lbu (zero-extend byte); 01 lbs (sign-extend byte); 10 lw / sw (full DATA_W word); store with 00 = sb; 11 for any access, or 01 with req_we=1, SHALL set rsp_err.
REQ-019 FSM states: INIT, IDLE, SPLIT; req_ready = 1 only in IDLE.
REQ-020 INIT: row counter 0..ROWS-1 writes byte k := k[7:0] for every byte k (including the last byte), one row per cycle; INIT -> IDLE after row ROWS-1 is written; init_busy = 1 throughout INIT.
REQ-021 Aligned access (byte access, or word with addr % BYTES == 0), accepted in cycle N: store commits at the edge ending N; rsp_valid = 1 in cycle N+1; state stays IDLE.
REQ-022 Misaligned word (addr % BYTES != 0): IDLE -> SPLIT for exactly one cycle, accessing row addr/BYTES first and row addr/BYTES+1 in SPLIT; rsp_valid in cycle N+2; req_ready = 0 in cycle N+1.
REQ-023 Misaligned load assembles bytes addr..addr+BYTES-1 in little-endian order; misaligned store writes those bytes only, leaving all others unchanged.
REQ-024 Error if addr >= DEPTH, or if a word's last byte addr+BYTES-1 >= DEPTH (no wrap-around); error responses: rsp_valid at N+1, no SPLIT, no memory change, rsp_data = 0, wb_sel = 0.
REQ-025 Back-to-back: an aligned request MAY be accepted in the same cycle its predecessor's rsp_valid is high; responses SHALL be in request order.
REQ-026 A store immediately followed by a load of the same bytes SHALL return the new data.
REQ-027 rsp_data, rsp_err and wb_sel SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-028 While reset = 1: state := INIT, row counter := 0, rsp_valid, rsp_err, wb_sel, rsp_data, req_ready := 0, init_busy := 1.
REQ-029 Reset during SPLIT SHALL abandon the request with no response; INIT then re-initialises every byte, including any first-row bytes already stored.
REQ-030 Requests presented during INIT SHALL NOT be accepted.

Verification (DATA_W=16, DEPTH=256)
REQ-031 Release reset -> init_busy high exactly 128 cycles, req_ready rises the next cycle; lw 0x0010 -> rsp_data 0x1110 at N+1, wb_sel 1.
REQ-032 lbs 0x0090 -> 0xFF90; lbu 0x0090 -> 0x0090; lbs 0x0070 -> 0x0070.
REQ-033 sw 0x0021 data 0xBEEF -> req_ready low one cycle, rsp at N+2; then lw 0x0021 -> 0xBEEF; lw 0x0022 -> 0x23BE; lbu 0x0020 -> 0x0020.
REQ-034 lw 0x00FF -> rsp_err 1 at N+1, no SPLIT; lbu 0x0100 -> rsp_err 1; func variant 11 -> rsp_err 1; sw to 0x00FF then lbu 0x00FF -> 0x00FF (unchanged).
REQ-035 Back-to-back sb 0x0005 data 0x00AA then lbu 0x0005 on consecutive cycles -> second response 0x00AA, both rsp_valid in consecutive cycles.
REQ-036 Reset asserted in SPLIT of sw 0x0041 data 0x1234 -> no response; after re-init, lw 0x0040 -> 0x4140 and lw 0x0042 -> 0x4342.
